// File: rtl/hazard_stall_ctrl.sv
// RAW-hazard scoreboard, EX-redirect flush and debug halt/drain control for a 5-stage non-forwarding pipe.
// Enables/flushes are combinational from ID/EX state; halted_o/busy_o are registered. Optional counters: HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int PIPE_DEPTH     = 3,
    parameter int RF_WRITE_FIRST = 1,
    parameter int REG_AW         = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic              id_rs1_used_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_we_i,
    input  logic              ex_redirect_i,
    input  logic              halt_req_i,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              halted_o,
    output logic              busy_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    localparam int CHK_DEPTH = PIPE_DEPTH - RF_WRITE_FIRST;

    state_e                             state_q;
    logic                               halted_q;
    logic                               busy_q;
    logic [PIPE_DEPTH-1:0]              sb_v_q, sb_v_d;
    logic [PIPE_DEPTH-1:0][REG_AW-1:0]  sb_rd_q, sb_rd_d;
    logic                               match1, match2;
    logic                               hazard;
    logic                               run;
    logic                               issue;

    // Entries at or beyond CHK_DEPTH are already visible through the register file.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (i < CHK_DEPTH && sb_v_q[i] && sb_rd_q[i] == id_rs1_i) match1 = 1'b1;
            if (i < CHK_DEPTH && sb_v_q[i] && sb_rd_q[i] == id_rs2_i) match2 = 1'b1;
        end
    end

    assign hazard = id_valid_i &&
                    ((id_rs1_used_i && id_rs1_i != '0 && match1) ||
                     (id_rs2_used_i && id_rs2_i != '0 && match2));
    assign run    = (state_q == RUN);
    assign issue  = id_valid_i && !hazard && !ex_redirect_i && run;

    always_comb begin
        sb_v_d     = '0;
        sb_rd_d    = '0;
        sb_v_d[0]  = issue && id_rd_we_i && (id_rd_i != '0);
        sb_rd_d[0] = issue ? id_rd_i : '0;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            sb_v_d[i]  = sb_v_q[i-1];
            sb_rd_d[i] = sb_rd_q[i-1];
        end
    end

    always_comb begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if (rst_i) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (ex_redirect_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (!run || hazard) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
            sb_v_q   <= '0;
            sb_rd_q  <= '0;
        end else begin
            sb_v_q  <= sb_v_d;
            sb_rd_q <= sb_rd_d;
            busy_q  <= |sb_v_d;
            case (state_q)
                RUN: begin
                    if (halt_req_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!halt_req_i) begin
                        state_q <= RUN;
                    end else if (sb_v_d == '0) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req_i) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign halted_o = halted_q;
    assign busy_o   = busy_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ex_redirect_i && run && hazard) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ex_redirect_i)                   flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
